dvp_camera_emitter: RTL and testbench

Drives a camera-style DVP pixel bus from a 16-bit RGB565 pixel stream: it generates `vsync`, `href` and an 8-bit `data` bus, two bytes per pixel, high byte first. The timing matches what `multi_camera_capture` expects on each camera port. It serves as an on-FPGA camera stand-in for loopback and bring-up, and as a bus-functional source for capture-side verification. Frame timing is free-running, and pixel supply never stalls the bus.

---
 rtl/dvp_camera_emitter_if.sv | 37 +++
 rtl/dvp_camera_emitter.sv | 203 ++++++++++++++++++++
 tb/tb_dvp_camera_emitter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/dvp_camera_emitter_if.sv
// DVP emitter bus bundle: the RGB565 pixel stream feeding the emitter, the run controls,
// and the camera-style DVP outputs it drives.
//   master : the emitter side (consumes pixels and controls, drives the DVP bus)
//   slave  : the environment side (supplies pixels and controls, observes the DVP bus)
// Signals:
//   enable     run frames (sampled in IDLE and at frame end)
//   pat_en     select internal test pattern (only honoured when the generator is built)
//   s_pixel    RGB565 input pixel
//   s_valid    input pixel valid
//   s_ready    pixel consumed this cycle
//   vsync      frame sync, active-high
//   href       line valid, active-high
//   data       byte bus, high byte of each pixel first
//   frame_done one-cycle pulse at the end of each frame
//   underflow  sticky: a pixel was needed while s_valid was low
interface dvp_camera_emitter_if;
    logic        enable;
    logic        pat_en;
    logic [15:0] s_pixel;
    logic        s_valid;
    logic        s_ready;
    logic        vsync;
    logic        href;
    logic [7:0]  data;
    logic        frame_done;
    logic        underflow;

    modport master (
        input  enable, pat_en, s_pixel, s_valid,
        output s_ready, vsync, href, data, frame_done, underflow
    );

    modport slave (
        output enable, pat_en, s_pixel, s_valid,
        input  s_ready, vsync, href, data, frame_done, underflow
    );
endinterface

// File: rtl/dvp_camera_emitter.sv
// Camera stand-in: turns an RGB565 pixel stream into DVP vsync/href/data, two bytes per
// pixel, high byte first. Frame timing is free-running; a missing pixel is replaced by
// 16'h0000 and flagged on the sticky underflow output instead of stalling the bus.
//
// Ports:
//   pclk  pixel/byte clock, rising edge
//   rst   asynchronous, active-low reset
//   bus   dvp_camera_emitter_if.master (stream input, enable/pat_en, DVP outputs)
//
// Build option: define DVP_TX_PATTERN_EN to build the internal pattern generator
// (pixel = 16'hF800 + column, selected by pat_en latched at frame start). Without it,
// pat_en is ignored and the stream is always used.
//
// All outputs are registered from the current state, so they lag the FSM by one cycle.
// s_ready is registered from the next state so that it leads the high byte by one cycle.
module dvp_camera_emitter #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned VSYNC_LEN = 4,
    parameter int unsigned VBP       = 2,
    parameter int unsigned H_BLANK   = 10,
    parameter int unsigned VFP       = 2
) (
    input logic                  pclk,
    input logic                  rst,
    dvp_camera_emitter_if.master bus
);

    localparam int unsigned BytesPerLine = 2 * H_ACTIVE;
    localparam int unsigned Max0   = (VSYNC_LEN > VBP) ? VSYNC_LEN : VBP;
    localparam int unsigned Max1   = (Max0 > BytesPerLine) ? Max0 : BytesPerLine;
    localparam int unsigned Max2   = (Max1 > H_BLANK) ? Max1 : H_BLANK;
    localparam int unsigned CntMax = (Max2 > VFP) ? Max2 : VFP;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned LineW  = $clog2(V_ACTIVE + 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StVsync  = 3'd1;
    localparam logic [2:0] StVbp    = 3'd2;
    localparam logic [2:0] StActive = 3'd3;
    localparam logic [2:0] StHblank = 3'd4;
    localparam logic [2:0] StVfp    = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;      // per-state cycle counter; byte index in ACTIVE
    logic [LineW-1:0] line_q, line_d;
    logic             pat_q, pat_d;      // pattern selected for the current frame
    logic [15:0]      hold_q, hold_d;    // pixel whose low byte goes out next
    logic             vsync_q, vsync_d;
    logic             href_q, href_d;
    logic [7:0]       data_q, data_d;
    logic             s_ready_q, s_ready_d;
    logic             frame_done_q, frame_done_d;
    logic             underflow_q, underflow_d;

    logic             pat_sel;
    logic [15:0]      src_pixel;

`ifdef DVP_TX_PATTERN_EN
    assign pat_sel   = bus.pat_en;
    // Column index is the byte index halved; identical on every row.
    assign src_pixel = pat_q ? (16'hF800 + 16'(cnt_q >> 1))
                             : ((s_ready_q && bus.s_valid) ? bus.s_pixel : 16'h0000);
`else
    logic unused_pat_en;
    assign unused_pat_en = bus.pat_en;
    assign pat_sel       = 1'b0;
    assign src_pixel     = (s_ready_q && bus.s_valid) ? bus.s_pixel : 16'h0000;
`endif

    // Frame sequencing.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        line_d       = line_q;
        pat_d        = pat_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.enable) begin
                    state_d = StVsync;
                    cnt_d   = '0;
                    pat_d   = pat_sel;
                end
            end
            StVsync: begin
                if (cnt_q == CntW'(VSYNC_LEN - 1)) begin
                    state_d = StVbp;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StVbp: begin
                if (cnt_q == CntW'(VBP - 1)) begin
                    state_d = StActive;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StActive: begin
                if (cnt_q == CntW'(BytesPerLine - 1)) begin
                    state_d = StHblank;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHblank: begin
                if (cnt_q == CntW'(H_BLANK - 1)) begin
                    cnt_d = '0;
                    if (line_q == LineW'(V_ACTIVE - 1)) begin
                        state_d = StVfp;
                        line_d  = '0;
                    end else begin
                        state_d = StActive;
                        line_d  = line_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StVfp: begin
                if (cnt_q == CntW'(VFP - 1)) begin
                    frame_done_d = 1'b1;
                    cnt_d        = '0;
                    if (bus.enable) begin
                        state_d = StVsync;
                        pat_d   = pat_sel;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                line_d  = '0;
            end
        endcase
    end

    // Output and pixel path.
    always_comb begin
        vsync_d     = (state_q == StVsync);
        href_d      = (state_q == StActive);
        data_d      = 8'h00;
        hold_d      = hold_q;
        underflow_d = underflow_q;
        // Ready leads the even byte it feeds by one cycle.
        s_ready_d   = (state_d == StActive) && !cnt_d[0] && !pat_d;
        if (state_q == StActive) begin
            if (!cnt_q[0]) begin
                data_d = src_pixel[15:8];
                hold_d = src_pixel;
                if (s_ready_q && !bus.s_valid) begin
                    underflow_d = 1'b1;
                end
            end else begin
                data_d = hold_q[7:0];
            end
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            line_q       <= '0;
            pat_q        <= 1'b0;
            hold_q       <= 16'h0000;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            data_q       <= 8'h00;
            s_ready_q    <= 1'b0;
            frame_done_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            line_q       <= line_d;
            pat_q        <= pat_d;
            hold_q       <= hold_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            data_q       <= data_d;
            s_ready_q    <= s_ready_d;
            frame_done_q <= frame_done_d;
            underflow_q  <= underflow_d;
        end
    end

    assign bus.vsync      = vsync_q;
    assign bus.href       = href_q;
    assign bus.data       = data_q;
    assign bus.s_ready    = s_ready_q;
    assign bus.frame_done = frame_done_q;
    assign bus.underflow  = underflow_q;

endmodule

// File: tb/tb_dvp_camera_emitter.sv
// Directed bench for dvp_camera_emitter with a 4x2 frame (VSYNC 4, VBP 2, HBLANK 10, VFP 2).
// Output time k=1 is the first vsync cycle; frame_done lands on k=44.
module tb_dvp_camera_emitter;

    localparam int H        = 4;
    localparam int V        = 2;
    localparam int VS       = 4;
    localparam int VB       = 2;
    localparam int HB       = 10;
    localparam int FP       = 2;
    localparam int LineLen  = 2 * H + HB;               // 18
    localparam int FirstK   = VS + VB + 1;              // 7
    localparam int FrameLen = VS + VB + V * LineLen + FP; // 44

    logic pclk = 1'b0;
    logic rst;
    always #5 pclk = ~pclk;

    dvp_camera_emitter_if bus ();

    dvp_camera_emitter #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .VSYNC_LEN(VS),
        .VBP      (VB),
        .H_BLANK  (HB),
        .VFP      (FP)
    ) dut (
        .pclk(pclk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int pi     = 0;   // stream pixel supply index
    int skip   = -1;  // frame pixel index withheld (s_valid=0)
    logic [15:0] tbl [8];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Answer the ready the DUT shows this cycle; the pixel is taken at the next edge.
    task automatic supply();
        if (bus.s_ready === 1'b1) begin
            if ((pi % 8) == skip) begin
                bus.s_valid = 1'b0;
                bus.s_pixel = 16'hFFFF;
            end else begin
                bus.s_valid = 1'b1;
                bus.s_pixel = tbl[pi % 8];
            end
            pi++;
        end else begin
            bus.s_valid = 1'b1;
            bus.s_pixel = 16'hDEAD;
        end
    endtask

    task automatic check_quiet(input string tag, input logic exp_uf);
        chk({tag, " vsync"}, 16'(bus.vsync), 16'(0));
        chk({tag, " href"}, 16'(bus.href), 16'(0));
        chk({tag, " data"}, 16'(bus.data), 16'(0));
        chk({tag, " s_ready"}, 16'(bus.s_ready), 16'(0));
        chk({tag, " frame_done"}, 16'(bus.frame_done), 16'(0));
        chk({tag, " underflow"}, 16'(bus.underflow), 16'(exp_uf));
    endtask

    // One full frame starting with the first vsync cycle at the next edge.
    task automatic run_frame(input int skip_idx, input int drop_at, input logic uf_before,
                             input logic pat);
        int rel, ln, w, pix_i;
        logic e_vs, e_href, e_rdy, e_fd, e_uf;
        logic [7:0] e_data;
        logic [15:0] p;
        skip = skip_idx;
        for (int k = 1; k <= FrameLen; k++) begin
            step();
            e_vs   = (k <= VS);
            e_href = 1'b0;
            e_data = 8'h00;
            e_rdy  = 1'b0;
            if (k >= FirstK && k < FirstK + V * LineLen) begin
                rel = k - FirstK;
                ln  = rel / LineLen;
                w   = rel % LineLen;
                if (w < 2 * H) begin
                    e_href = 1'b1;
                    pix_i  = ln * H + w / 2;
                    if (pat) p = 16'hF800 + 16'(w / 2);
                    else if (pix_i == skip_idx) p = 16'h0000;
                    else p = tbl[pix_i];
                    e_data = (w % 2 == 0) ? p[15:8] : p[7:0];
                end
            end
            if (!pat && k + 1 >= FirstK && k + 1 < FirstK + V * LineLen) begin
                rel   = k + 1 - FirstK;
                w     = rel % LineLen;
                e_rdy = (w < 2 * H) && (w % 2 == 0);
            end
            e_fd = (k == FrameLen);
            e_uf = uf_before ||
                   (skip_idx >= 0 && k >= FirstK + (skip_idx / H) * LineLen + 2 * (skip_idx % H));
            chk($sformatf("vsync k=%0d", k), 16'(bus.vsync), 16'(e_vs));
            chk($sformatf("href k=%0d", k), 16'(bus.href), 16'(e_href));
            chk($sformatf("data k=%0d", k), 16'(bus.data), 16'(e_data));
            chk($sformatf("s_ready k=%0d", k), 16'(bus.s_ready), 16'(e_rdy));
            chk($sformatf("frame_done k=%0d", k), 16'(bus.frame_done), 16'(e_fd));
            chk($sformatf("underflow k=%0d", k), 16'(bus.underflow), 16'(e_uf));
            if (k == drop_at) bus.enable = 1'b0;
            supply();
        end
    endtask

    initial begin
        tbl[0] = 16'hA1B2; tbl[1] = 16'hC3D4; tbl[2] = 16'hE5F6; tbl[3] = 16'h0718;
        tbl[4] = 16'h293A; tbl[5] = 16'h4B5C; tbl[6] = 16'h6D7E; tbl[7] = 16'h8F90;
        rst         = 1'b0;
        bus.enable  = 1'b0;
        bus.pat_en  = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_pixel = 16'h0000;

        // Reset values, then idle with enable low.
        #2;
        check_quiet("reset", 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_quiet("in_reset", 1'b0);
        end
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_quiet("idle", 1'b0);
        end

        // Frame 1: continuous stream; enable seen at this edge, vsync follows one edge later.
        bus.enable = 1'b1;
        step();
        check_quiet("start1", 1'b0);
        run_frame(-1, -1, 1'b0, 1'b0);

        // Frame 2 back-to-back: third pixel of line 0 withheld, enable dropped in line 1.
        run_frame(2, 26, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            check_quiet("after_stop", 1'b1);
        end

`ifdef DVP_TX_PATTERN_EN
        bus.pat_en = 1'b1;
        bus.enable = 1'b1;
        step();
        check_quiet("start_pat", 1'b1);
        run_frame(-1, 30, 1'b1, 1'b1);
        bus.pat_en = 1'b0;
        step();
        check_quiet("after_pat", 1'b1);
`endif

        // Reset in the middle of line 0 of a new frame.
        bus.enable = 1'b1;
        skip = -1;
        step();
        check_quiet("start3", 1'b1);
        for (int k = 1; k <= 9; k++) begin
            step();
            supply();
        end
        chk("href before reset", 16'(bus.href), 16'(1));
        #2;
        rst = 1'b0;
        #1;
        check_quiet("async_reset", 1'b0);
        step();
        check_quiet("held_reset", 1'b0);
        rst = 1'b1;
        pi  = 0;
        step();
        check_quiet("start4", 1'b0);
        run_frame(-1, 30, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_quiet("final_idle", 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
